// File: rtl/process_meter_if.sv
// process_meter_if
//   Bundles the playback-progress signals between the player core (master)
//   and the process_meter engine (slave).
//   Master drives : ram_addr_out, music_len, bar_mode
//   Slave drives  : process, process_bar, process_full, process_upd, busy
interface process_meter_if #(
  parameter int ADDR_W  = 12,
  parameter int NUM_SEG = 16,
  parameter int SEG_W   = 5
);
  logic [ADDR_W-1:0]  ram_addr_out;
  logic [ADDR_W-1:0]  music_len;
  logic               bar_mode;
  logic [SEG_W-1:0]   process;
  logic [NUM_SEG-1:0] process_bar;
  logic               process_full;
  logic               process_upd;
  logic               busy;

  modport master (
    output ram_addr_out, music_len, bar_mode,
    input  process, process_bar, process_full, process_upd, busy
  );

  modport slave (
    input  ram_addr_out, music_len, bar_mode,
    output process, process_bar, process_full, process_upd, busy
  );
endinterface

// File: rtl/process_meter.sv
// process_meter
//   Playback-progress engine for the display path. Computes
//   floor(addr*NUM_SEG/len) clamped to NUM_SEG with a restoring divider
//   (one quotient bit per cycle) and turns it into a fill or cursor bar.
//   Ports:
//     sys_clk      : system clock
//     sys_rst_n    : asynchronous active-low reset
//     pm (slave)   : ram_addr_out, music_len, bar_mode in;
//                    process, process_bar, process_full, process_upd, busy out
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | compare inputs with snapshot; start a computation on change
//   DIV    | one restoring-subtract step per cycle, DIV_W steps total
//   DONE   | clamp quotient, register count/bar/full, pulse upd on change
module process_meter #(
  parameter int ADDR_W    = 12,
  parameter int NUM_SEG   = 16,
  parameter int SEG_W     = 5,
  parameter int POS_SHIFT = 2
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  process_meter_if.slave  pm
);

  localparam int DIV_W = ADDR_W + SEG_W;
  localparam int KEY_W = ADDR_W - POS_SHIFT;
  localparam int CNT_W = $clog2(DIV_W);

  localparam logic [DIV_W-1:0] SEG_MUL  = DIV_W'(NUM_SEG);
  localparam logic [SEG_W-1:0] SEG_MAX  = SEG_W'(NUM_SEG);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t             state;
  logic [KEY_W-1:0]   key_q;
  logic [ADDR_W-1:0]  len_q;
  logic               mode_q;
  // Dividend shifts out at the top while quotient bits shift in at the
  // bottom; after DIV_W steps the register holds the full quotient.
  logic [DIV_W-1:0]   dq;
  logic [ADDR_W-1:0]  rem;
  logic [CNT_W-1:0]   cnt;

  logic               trigger;
  logic [ADDR_W:0]    rem_sh;
  logic               sub_ok;
  logic [ADDR_W-1:0]  rem_sub;
  logic [SEG_W-1:0]   q_res;
  logic [NUM_SEG-1:0] bar_fill;
  logic [NUM_SEG-1:0] bar_cur;
  logic [NUM_SEG-1:0] bar_res;

  always_comb begin
    trigger = (pm.ram_addr_out[ADDR_W-1:POS_SHIFT] != key_q) ||
              (pm.music_len != len_q) ||
              (pm.bar_mode != mode_q);

    rem_sh  = {rem, dq[DIV_W-1]};
    sub_ok  = (rem_sh >= {1'b0, len_q});
    // Difference is below len whenever it is used, so ADDR_W bits suffice.
    rem_sub = rem_sh[ADDR_W-1:0] - len_q;

    if (len_q == '0)
      q_res = '0;
    else if (dq > SEG_MUL)
      q_res = SEG_MAX;
    else
      q_res = dq[SEG_W-1:0];

    bar_fill = '0;
    bar_cur  = '0;
    for (int i = 0; i < NUM_SEG; i++) begin
      bar_fill[i] = (int'(q_res) > i);
      bar_cur[i]  = (int'(q_res) == i + 1);
    end
    bar_res = mode_q ? bar_cur : bar_fill;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state           <= S_IDLE;
      key_q           <= '0;
      len_q           <= '0;
      mode_q          <= 1'b0;
      dq              <= '0;
      rem             <= '0;
      cnt             <= '0;
      pm.process      <= '0;
      pm.process_bar  <= '0;
      pm.process_full <= 1'b0;
      pm.process_upd  <= 1'b0;
      pm.busy         <= 1'b0;
    end else begin
      pm.process_upd <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            key_q   <= pm.ram_addr_out[ADDR_W-1:POS_SHIFT];
            len_q   <= pm.music_len;
            mode_q  <= pm.bar_mode;
            dq      <= {{SEG_W{1'b0}}, pm.ram_addr_out} * SEG_MUL;
            rem     <= '0;
            cnt     <= CNT_LAST;
            pm.busy <= 1'b1;
            state   <= (pm.music_len == '0) ? S_DONE : S_DIV;
          end
        end

        S_DIV: begin
          rem <= sub_ok ? rem_sub : rem_sh[ADDR_W-1:0];
          dq  <= {dq[DIV_W-2:0], sub_ok};
          if (cnt == '0)
            state <= S_DONE;
          else
            cnt <= cnt - 1'b1;
        end

        S_DONE: begin
          pm.process      <= q_res;
          pm.process_bar  <= bar_res;
          pm.process_full <= (q_res == SEG_MAX);
          pm.process_upd  <= (q_res != pm.process) || (bar_res != pm.process_bar);
          pm.busy         <= 1'b0;
          state           <= S_IDLE;
        end

        default: begin
          pm.busy <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_process_meter.sv
// tb_process_meter
//   Directed bench for process_meter: default build plus a NUM_SEG=10 build.
//   Expected results come from a direct arithmetic model and are queued when
//   stimulus is driven, then popped when the DUT finishes a computation.
module tb_process_meter;

  localparam int ADDR_W  = 12;
  localparam int NUM_SEG = 16;
  localparam int SEG_W   = 5;
  localparam int DIV_W   = ADDR_W + SEG_W;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;

  always #5 sys_clk = ~sys_clk;

  process_meter_if #(.ADDR_W(ADDR_W), .NUM_SEG(NUM_SEG), .SEG_W(SEG_W)) pm();
  process_meter_if #(.ADDR_W(ADDR_W), .NUM_SEG(10), .SEG_W(4)) pm10();

  process_meter #(
    .ADDR_W(ADDR_W), .NUM_SEG(NUM_SEG), .SEG_W(SEG_W), .POS_SHIFT(2)
  ) u_dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pm        (pm)
  );

  process_meter #(
    .ADDR_W(ADDR_W), .NUM_SEG(10), .SEG_W(4), .POS_SHIFT(2)
  ) u_dut10 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pm        (pm10)
  );

  typedef struct {
    int          q;
    logic [15:0] bar;
    bit          full;
    bit          upd;
    bit          zero_len;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passed = 0;
  int          fails  = 0;
  int          prev_q = 0;
  logic [15:0] prev_bar = '0;
  int          cur_len = 0;

  function automatic int model_q(input int addr, input int len, input int nseg);
    int q;
    if (len == 0) return 0;
    q = (addr * nseg) / len;
    return (q > nseg) ? nseg : q;
  endfunction

  function automatic logic [15:0] model_bar(input int q, input bit mode);
    logic [15:0] b;
    for (int i = 0; i < 16; i++)
      b[i] = mode ? (i == q - 1) : (i < q);
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int addr, input int len, input bit mode);
    pm.ram_addr_out = addr[ADDR_W-1:0];
    pm.music_len    = len[ADDR_W-1:0];
    pm.bar_mode     = mode;
    cur_len         = len;
  endtask

  task automatic push_exp(input int addr, input int len, input bit mode);
    exp_t e;
    e.q        = model_q(addr, len, NUM_SEG);
    e.bar      = model_bar(e.q, mode);
    e.full     = (e.q == NUM_SEG);
    e.upd      = (e.q != prev_q) || (e.bar != prev_bar);
    e.zero_len = (len == 0);
    prev_q     = e.q;
    prev_bar   = e.bar;
    sb.push_back(e);
  endtask

  // Waits for one computation (busy rise then fall), bounded at 40 edges.
  task automatic wait_result(input string tag);
    exp_t e;
    int   busy_cnt  = 0;
    int   edge_n    = 0;
    int   upd_early = 0;
    bit   done      = 1'b0;
    e = sb.pop_front();
    for (int i = 1; i <= 40; i++) begin
      @(posedge sys_clk); #1;
      if (pm.busy) begin
        busy_cnt++;
        if (pm.process_upd) upd_early++;
      end else if (busy_cnt > 0) begin
        edge_n = i;
        done   = 1'b1;
        break;
      end
    end
    check({tag, "/done"}, 32'(done), 32'd1);
    check({tag, "/latency"}, edge_n, e.zero_len ? 2 : DIV_W + 2);
    check({tag, "/busy_cycles"}, busy_cnt, e.zero_len ? 1 : DIV_W + 1);
    check({tag, "/upd_early"}, upd_early, 0);
    check({tag, "/process"}, 32'(pm.process), e.q);
    check({tag, "/bar"}, 32'(pm.process_bar), 32'(e.bar));
    check({tag, "/full"}, 32'(pm.process_full), 32'(e.full));
    check({tag, "/upd"}, 32'(pm.process_upd), 32'(e.upd));
    @(posedge sys_clk); #1;
    check({tag, "/upd_clear"}, 32'(pm.process_upd), 32'd0);
  endtask

  task automatic no_activity(input string tag, input int n);
    int busy_seen = 0;
    int upd_seen  = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk); #1;
      if (pm.busy) busy_seen++;
      if (pm.process_upd) upd_seen++;
    end
    check({tag, "/busy_seen"}, busy_seen, 0);
    check({tag, "/upd_seen"}, upd_seen, 0);
    check({tag, "/process"}, 32'(pm.process), prev_q);
    check({tag, "/bar"}, 32'(pm.process_bar), 32'(prev_bar));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/process"}, 32'(pm.process), 32'd0);
    check({tag, "/bar"}, 32'(pm.process_bar), 32'd0);
    check({tag, "/full"}, 32'(pm.process_full), 32'd0);
    check({tag, "/upd"}, 32'(pm.process_upd), 32'd0);
    check({tag, "/busy"}, 32'(pm.busy), 32'd0);
  endtask

  task automatic check_dut10(input string tag);
    logic [15:0] b;
    int          q;
    q = model_q(999, 1000, 10);
    b = model_bar(q, 1'b0);
    check({tag, "/process"}, 32'(pm10.process), q);
    check({tag, "/bar"}, 32'(pm10.process_bar), 32'(b[9:0]));
    check({tag, "/full"}, 32'(pm10.process_full), 32'(q == 10));
  endtask

  initial begin
    int  r_addr;
    int  r_len;
    bit  r_mode;

    drive(0, 0, 1'b0);
    pm10.ram_addr_out = '0;
    pm10.music_len    = '0;
    pm10.bar_mode     = 1'b0;

    // Reset takes effect before the first clock edge.
    #2 sys_rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    no_activity("post_reset_idle", 5);

    pm10.ram_addr_out = 12'd999;
    pm10.music_len    = 12'd1000;

    drive(400, 1600, 1'b0);  push_exp(400, 1600, 1'b0);  wait_result("fill_400");
    check_dut10("seg10");

    drive(1600, 1600, 1'b0); push_exp(1600, 1600, 1'b0); wait_result("addr_eq_len");
    drive(2000, 1600, 1'b0); push_exp(2000, 1600, 1'b0); wait_result("addr_gt_len");
    drive(400, 1600, 1'b0);  push_exp(400, 1600, 1'b0);  wait_result("back_to_4");

    drive(900, 0, 1'b0);     push_exp(900, 0, 1'b0);     wait_result("len0_from4");
    drive(908, 0, 1'b0);     push_exp(908, 0, 1'b0);     wait_result("len0_nochg");

    drive(400, 1600, 1'b0);  push_exp(400, 1600, 1'b0);  wait_result("fill_again");
    drive(401, 1600, 1'b0);  no_activity("bucket_401", 25);
    drive(403, 1600, 1'b0);  no_activity("bucket_403", 25);
    drive(404, 1600, 1'b0);  push_exp(404, 1600, 1'b0);  wait_result("bucket_404");

    drive(404, 1600, 1'b1);  push_exp(404, 1600, 1'b1);  wait_result("cursor_4");

    // Reset in the middle of DIV: edge k enters DIV, 7 more edges are steps.
    drive(800, 1600, 1'b0);
    repeat (8) @(posedge sys_clk);
    #1;
    check("mid_div/busy", 32'(pm.busy), 32'd1);
    sys_rst_n = 1'b0;
    #1 check_all_zero("mid_div_reset");
    prev_q   = 0;
    prev_bar = '0;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    push_exp(800, 1600, 1'b0);
    wait_result("after_reset");
    check_dut10("seg10_after_reset");

    for (int n = 0; n < 4; n++) begin
      r_len = $urandom_range(1, 4095);
      if (r_len == cur_len) r_len = (r_len % 4095) + 1;
      r_addr = $urandom_range(0, 4095);
      r_mode = 1'($urandom_range(0, 1));
      drive(r_addr, r_len, r_mode);
      push_exp(r_addr, r_len, r_mode);
      wait_result($sformatf("rand%0d", n));
    end

    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/process_meter.md
# process_meter

Parametrised playback-progress engine for the KeyTunePlayer display path. It compares the RAM read address `ram_addr_out` against the song length `music_len` and produces an exact segment count, `floor(addr*NUM_SEG/len)`, clamped to `NUM_SEG`, using a sequential restoring divider. From that count it builds a registered bar pattern, in either fill or cursor mode, for the LED/segment driver. It recomputes only when the coarse play position, the length or the mode changes, and flags every change of the displayed value with a one-cycle pulse.

## Interface
- `ADDR_W`, 12: width of `ram_addr_out` and `music_len`.
- `NUM_SEG`, 16: number of bar segments, 1..(2^SEG_W − 1).
- `SEG_W`, 5: width of `process`; must hold the value `NUM_SEG`.
- `POS_SHIFT`, 2: coarse-position granularity. A recompute triggers when `ram_addr_out>>POS_SHIFT` changes.
- `sys_clk` in 1: system clock, 100 MHz. The block has one clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `ram_addr_out` in ADDR_W: current playback address.
- `music_len` in ADDR_W: song length in addresses; 0 means no song loaded.
- `bar_mode` in 1: 0 selects fill (thermometer), 1 selects cursor (single segment).
- `process` out SEG_W: segment count, 0..NUM_SEG.
- `process_bar` out NUM_SEG: bar pattern; bit 0 is the first segment.
- `process_full` out 1: 1 when `process == NUM_SEG`.
- `process_upd` out 1: one-cycle pulse when `process` or `process_bar` changes value.
- `busy` out 1: 1 while the state machine is outside IDLE.

## Operation
- DIV_W = ADDR_W + SEG_W.
- Dividend = `addr*NUM_SEG`, computed at full DIV_W width with no truncation.
- Quotient = DIV_W bits, one bit resolved per cycle, MSB first.
- Snapshot registers hold `key` (ADDR_W−POS_SHIFT bits), `len` and `mode`.
  - All three reset to 0.
  - They are loaded whenever a computation starts.
- FSM states: IDLE, DIV, DONE.
- IDLE:
  - Trigger = `(ram_addr_out>>POS_SHIFT) != key`, or `music_len != len`, or `bar_mode != mode`.
  - On trigger, load the snapshot, latch the full `ram_addr_out` as the operand, and reset the remainder and the bit counter.
  - Next state is DIV, or DONE directly when `music_len == 0`.
- DIV:
  - One restoring-subtract step per cycle.
  - After exactly DIV_W steps, go to DONE.
  - Input changes during DIV are ignored; they are caught by the IDLE compare after DONE.
- DONE:
  - q = 0 if the latched len == 0. Otherwise q = min(quotient, NUM_SEG); this covers addr ≥ len.
  - Register `process <= q`.
  - Register `process_bar`:
    - Fill mode: bits [q−1:0] set.
    - Cursor mode: only bit q−1 set; all zero when q = 0.
  - `process_full <= (q == NUM_SEG)`.
  - `process_upd <= 1` only if the new `process` or `process_bar` differs from the current value.
  - Next state is IDLE.
- `process_upd` is 0 in every cycle other than the cycle following a DONE that changed an output.
- A new trigger already present in IDLE on the cycle after DONE starts immediately. No idle gap is required.

## Timing
- Reset (asynchronous, immediate):
  - State = IDLE.
  - `process` = 0, `process_bar` = 0, `process_full` = 0, `process_upd` = 0, `busy` = 0.
  - Snapshot and datapath cleared.
- Reset asserted mid-DIV aborts the computation with no output update. After release:
  - A recompute starts only if the inputs differ from the zeroed snapshot.
  - With `music_len == 0`, the outputs therefore stay 0 with no pulse.
- Latency, nonzero length: input change visible before edge k.
  - Edge k: IDLE→DIV.
  - Edge k+DIV_W: DIV→DONE.
  - Edge k+DIV_W+1: outputs updated, `process_upd` high for that one cycle.
  - With defaults, outputs update 18 edges after the trigger edge.
- Latency, zero length: edge k: IDLE→DONE; edge k+1: outputs updated.
- `busy` is high from edge k until edge k+DIV_W+1 (or until k+1 for zero length).
- Throughput: at most one result per DIV_W+2 cycles. A changing input is never lost; the last value wins.
- Address changes within the same `>>POS_SHIFT` bucket cause no activity.

## Test plan
- Defaults, `music_len`=1600, `ram_addr_out`=400, mode 0 → after 18 edges: `process`=4, `process_bar`=0x000F, `process_upd` one pulse, `busy` high for exactly 18 cycles.
- `ram_addr_out`=1600, then 2000 → `process`=16, `process_full`=1, `process_bar`=0xFFFF. The second computation gives no `process_upd` pulse.
- `music_len`=0, `ram_addr_out`=900 → after 2 edges `process`=0 and bar 0. No pulse if outputs were already 0; pulse if the previous value was 4.
- `ram_addr_out` 400→401→403 with len 1600 → `busy` stays 0 and there is no recompute. Then 404 → recompute: `process`=4, no pulse.
- `process`=4 and `bar_mode` 0→1 → recompute, `process_bar`=0x0008, `process` unchanged, one pulse. Non-power-of-2 build (NUM_SEG=10, len=1000, addr=999) → `process`=9.
- Assert `sys_rst_n` at DIV cycle 7 with len 1600 and addr 800 → all outputs 0 at once. After release the recompute gives `process`=8 with correct latency.
